pipeline_stage_regs: RTL and testbench
======================================

Name: pipeline_stage_regs

Overview:
- Bundles the three front-end pipeline registers of the 5-stage 64-bit ARM-style CPU (IF/ID, ID/EX, EX/MEM) into one block.
- Each stage captures its upstream signals on the rising clock edge and presents them to the next stage.
- Each stage has its own hold enable, so the hazard unit can stall stages independently.

Parameters:
- DATA_W, 64, width of data/address/PC fields
- INSTR_W, 32, instruction width
- REG_W, 5, register-specifier width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- ifid_en  in  1  IF/ID load enable
- ifid_instr_i / ifid_instr_o  in/out  INSTR_W  fetched instruction
- ifid_pc_i / ifid_pc_o  in/out  DATA_W  PC of fetched instruction
- idex_en  in  1  ID/EX load enable
- idex_rd1_i / idex_rd1_o, idex_rd2_i / idex_rd2_o  in/out  DATA_W  register-file read data 1/2
- idex_pc_i / idex_pc_o  in/out  DATA_W  PC carried to branch adder
- idex_se_i / idex_se_o  in/out  DATA_W  sign-extended immediate
- idex_rn_i/_o, idex_rm_i/_o, idex_rd_i/_o  in/out  REG_W  source/dest register numbers
- idex_ex_i / idex_ex_o  in/out  6  EX controls {FlagEn, ShiftDir, ALUSrc, ALUOp[2:0]}
- idex_m_i / idex_m_o  in/out  5  MEM controls {BrSel, Branch, UBranch, MemWrite, MemRead}
- idex_wb_i / idex_wb_o  in/out  2  WB controls {RegWrite, MemtoReg}
- exmem_en  in  1  EX/MEM load enable
- exmem_alu_i / exmem_alu_o  in/out  DATA_W  ALU result
- exmem_wdata_i / exmem_wdata_o  in/out  DATA_W  store data (forwarded Rm/Rd)
- exmem_addr_i / exmem_addr_o  in/out  DATA_W  branch target address
- exmem_rd_i / exmem_rd_o  in/out  REG_W  destination register
- exmem_m_i / exmem_m_o  in/out  5  MEM controls (same packing as idex_m)
- exmem_wb_i / exmem_wb_o  in/out  2  WB controls (same packing as idex_wb)
- exmem_aluflag_i / exmem_aluflag_o  in/out  4  raw ALU flags {Z, N, V, C}
- exmem_flag_i / exmem_flag_o  in/out  4  flag-register flags {Z, N, V, C}

Behaviour:
- All `_o` outputs are direct flop outputs; there is no combinational path from any input to any output.
- rst = 0 clears every stored field to 0 immediately, independent of clk. After reset:
  - instr = 32'h0
  - all control fields = 0, so no RegWrite, MemWrite or branch
  - all data fields = 0
- Reset release is synchronized by the caller. The first capture happens on the first rising edge with rst = 1.
- Stage with en = 1 at a rising edge: every field of that stage loads its `_i` value. Latency is exactly 1 cycle.
- Stage with en = 0: every field of that stage holds its value. Holding is all-or-nothing per stage; no partial updates.
- Stages are fully independent: any combination of enables is legal.
  - Example: ifid_en = 0 with idex_en = 1 re-issues the held instruction into ID/EX as well.
- Fields pass bit-exact, with no sign extension, truncation or reordering. Flag and control packing is preserved in order.
- Reset asserted mid-stream: all contents are lost immediately. Outputs stay 0 until the first enabled edge after release.

Optional Feature:
- Macro PIPE_FLUSH_EN adds inputs ifid_flush, idex_flush and exmem_flush (1 bit each, synchronous).
- With the macro defined, a rising edge with a stage's flush = 1 inserts a bubble:
  - IF/ID: instr becomes 32'h0.
  - ID/EX: ex, m and wb fields become 0.
  - EX/MEM: m and wb fields become 0.
  - Data, register-number and flag fields load normally if en = 1, otherwise hold.
- Flush takes priority over en = 0. Async reset takes priority over flush.
- Without the macro: the flush ports do not exist and the stages behave as above.

Test Plan:
- Async reset: load all stages with nonzero data (e.g. instr 32'h91000421, pc 64'h10), drop rst between edges -> every output reads 0 at once, before the next edge.
- Pass-through: all en = 1, drive ifid_pc_i = 64'h4, then 64'h8, then 64'hC on consecutive edges -> ifid_pc_o follows one cycle late. Feeding ifid_pc_o to idex_pc_i shows a two-cycle total delay.
- Stall: ifid_en = 0 for 2 cycles while ifid_instr_i changes -> ifid_instr_o holds 32'h8B020020. It updates on the first edge after ifid_en = 1.
- Independence: idex_en = 0, exmem_en = 1, exmem_alu_i = 64'hDEAD_BEEF -> exmem_alu_o = 64'hDEADBEEF while the ID/EX outputs stay frozen.
- Field integrity: idex_m_i = 5'b10101, idex_wb_i = 2'b10, exmem_aluflag_i = 4'b1001 -> outputs match bit-exactly one cycle later.
- PIPE_FLUSH_EN defined: idex_flush = 1 with idex_ex_i = 6'h3F, idex_wb_i = 2'b11, idex_rd1_i = 64'h5 -> ex/m/wb outputs = 0 and idex_rd1_o = 64'h5.

Source files
------------

// File: rtl/pipeline_stage_regs.sv
// pipeline_stage_regs
// IF/ID, ID/EX and EX/MEM pipeline registers of the 5-stage 64-bit ARM-style
// core. Each stage has its own load enable so the hazard unit can stall
// stages independently. Every output is a flop output.
// Optional macro PIPE_FLUSH_EN adds per-stage synchronous flush inputs that
// zero the instruction/control fields (bubble insertion).

module pipeline_stage_regs #(
   parameter int DATA_W  = 64,
   parameter int INSTR_W = 32,
   parameter int REG_W   = 5
) (
   input  logic               clk,
   input  logic               rst,
`ifdef PIPE_FLUSH_EN
   input  logic               ifid_flush,
   input  logic               idex_flush,
   input  logic               exmem_flush,
`endif
   // IF/ID
   input  logic               ifid_en,
   input  logic [INSTR_W-1:0] ifid_instr_i,
   output logic [INSTR_W-1:0] ifid_instr_o,
   input  logic [DATA_W-1:0]  ifid_pc_i,
   output logic [DATA_W-1:0]  ifid_pc_o,
   // ID/EX
   input  logic               idex_en,
   input  logic [DATA_W-1:0]  idex_rd1_i,
   output logic [DATA_W-1:0]  idex_rd1_o,
   input  logic [DATA_W-1:0]  idex_rd2_i,
   output logic [DATA_W-1:0]  idex_rd2_o,
   input  logic [DATA_W-1:0]  idex_pc_i,
   output logic [DATA_W-1:0]  idex_pc_o,
   input  logic [DATA_W-1:0]  idex_se_i,
   output logic [DATA_W-1:0]  idex_se_o,
   input  logic [REG_W-1:0]   idex_rn_i,
   output logic [REG_W-1:0]   idex_rn_o,
   input  logic [REG_W-1:0]   idex_rm_i,
   output logic [REG_W-1:0]   idex_rm_o,
   input  logic [REG_W-1:0]   idex_rd_i,
   output logic [REG_W-1:0]   idex_rd_o,
   input  logic [5:0]         idex_ex_i,
   output logic [5:0]         idex_ex_o,
   input  logic [4:0]         idex_m_i,
   output logic [4:0]         idex_m_o,
   input  logic [1:0]         idex_wb_i,
   output logic [1:0]         idex_wb_o,
   // EX/MEM
   input  logic               exmem_en,
   input  logic [DATA_W-1:0]  exmem_alu_i,
   output logic [DATA_W-1:0]  exmem_alu_o,
   input  logic [DATA_W-1:0]  exmem_wdata_i,
   output logic [DATA_W-1:0]  exmem_wdata_o,
   input  logic [DATA_W-1:0]  exmem_addr_i,
   output logic [DATA_W-1:0]  exmem_addr_o,
   input  logic [REG_W-1:0]   exmem_rd_i,
   output logic [REG_W-1:0]   exmem_rd_o,
   input  logic [4:0]         exmem_m_i,
   output logic [4:0]         exmem_m_o,
   input  logic [1:0]         exmem_wb_i,
   output logic [1:0]         exmem_wb_o,
   input  logic [3:0]         exmem_aluflag_i,
   output logic [3:0]         exmem_aluflag_o,
   input  logic [3:0]         exmem_flag_i,
   output logic [3:0]         exmem_flag_o
);

   logic w_ifidFlush;
   logic w_idexFlush;
   logic w_exmemFlush;

`ifdef PIPE_FLUSH_EN
   assign w_ifidFlush  = ifid_flush;
   assign w_idexFlush  = idex_flush;
   assign w_exmemFlush = exmem_flush;
`else
   assign w_ifidFlush  = 1'b0;
   assign w_idexFlush  = 1'b0;
   assign w_exmemFlush = 1'b0;
`endif

   logic [INSTR_W-1:0] r_ifidInstr;
   logic [DATA_W-1:0]  r_ifidPc;

   logic [DATA_W-1:0]  r_idexRd1;
   logic [DATA_W-1:0]  r_idexRd2;
   logic [DATA_W-1:0]  r_idexPc;
   logic [DATA_W-1:0]  r_idexSe;
   logic [REG_W-1:0]   r_idexRn;
   logic [REG_W-1:0]   r_idexRm;
   logic [REG_W-1:0]   r_idexRd;
   logic [5:0]         r_idexEx;
   logic [4:0]         r_idexM;
   logic [1:0]         r_idexWb;

   logic [DATA_W-1:0]  r_exmemAlu;
   logic [DATA_W-1:0]  r_exmemWdata;
   logic [DATA_W-1:0]  r_exmemAddr;
   logic [REG_W-1:0]   r_exmemRd;
   logic [4:0]         r_exmemM;
   logic [1:0]         r_exmemWb;
   logic [3:0]         r_exmemAluFlag;
   logic [3:0]         r_exmemFlag;

   // IF/ID: flush turns the instruction into a zero bubble, PC follows the enable
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ifidInstr <= '0;
         r_ifidPc    <= '0;
      end else begin
         if (w_ifidFlush)
            r_ifidInstr <= '0;
         else if (ifid_en)
            r_ifidInstr <= ifid_instr_i;
         if (ifid_en)
            r_ifidPc <= ifid_pc_i;
      end
   end

   // ID/EX: flush clears EX/M/WB controls, data and register numbers follow the enable
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_idexRd1 <= '0;
         r_idexRd2 <= '0;
         r_idexPc  <= '0;
         r_idexSe  <= '0;
         r_idexRn  <= '0;
         r_idexRm  <= '0;
         r_idexRd  <= '0;
         r_idexEx  <= '0;
         r_idexM   <= '0;
         r_idexWb  <= '0;
      end else begin
         if (w_idexFlush) begin
            r_idexEx <= '0;
            r_idexM  <= '0;
            r_idexWb <= '0;
         end else if (idex_en) begin
            r_idexEx <= idex_ex_i;
            r_idexM  <= idex_m_i;
            r_idexWb <= idex_wb_i;
         end
         if (idex_en) begin
            r_idexRd1 <= idex_rd1_i;
            r_idexRd2 <= idex_rd2_i;
            r_idexPc  <= idex_pc_i;
            r_idexSe  <= idex_se_i;
            r_idexRn  <= idex_rn_i;
            r_idexRm  <= idex_rm_i;
            r_idexRd  <= idex_rd_i;
         end
      end
   end

   // EX/MEM: flush clears M/WB controls, results and flags follow the enable
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_exmemAlu     <= '0;
         r_exmemWdata   <= '0;
         r_exmemAddr    <= '0;
         r_exmemRd      <= '0;
         r_exmemM       <= '0;
         r_exmemWb      <= '0;
         r_exmemAluFlag <= '0;
         r_exmemFlag    <= '0;
      end else begin
         if (w_exmemFlush) begin
            r_exmemM  <= '0;
            r_exmemWb <= '0;
         end else if (exmem_en) begin
            r_exmemM  <= exmem_m_i;
            r_exmemWb <= exmem_wb_i;
         end
         if (exmem_en) begin
            r_exmemAlu     <= exmem_alu_i;
            r_exmemWdata   <= exmem_wdata_i;
            r_exmemAddr    <= exmem_addr_i;
            r_exmemRd      <= exmem_rd_i;
            r_exmemAluFlag <= exmem_aluflag_i;
            r_exmemFlag    <= exmem_flag_i;
         end
      end
   end

   assign ifid_instr_o    = r_ifidInstr;
   assign ifid_pc_o       = r_ifidPc;
   assign idex_rd1_o      = r_idexRd1;
   assign idex_rd2_o      = r_idexRd2;
   assign idex_pc_o       = r_idexPc;
   assign idex_se_o       = r_idexSe;
   assign idex_rn_o       = r_idexRn;
   assign idex_rm_o       = r_idexRm;
   assign idex_rd_o       = r_idexRd;
   assign idex_ex_o       = r_idexEx;
   assign idex_m_o        = r_idexM;
   assign idex_wb_o       = r_idexWb;
   assign exmem_alu_o     = r_exmemAlu;
   assign exmem_wdata_o   = r_exmemWdata;
   assign exmem_addr_o    = r_exmemAddr;
   assign exmem_rd_o      = r_exmemRd;
   assign exmem_m_o       = r_exmemM;
   assign exmem_wb_o      = r_exmemWb;
   assign exmem_aluflag_o = r_exmemAluFlag;
   assign exmem_flag_o    = r_exmemFlag;

endmodule

// File: tb/tb_pipeline_stage_regs.sv
// tb_pipeline_stage_regs
// Directed bench for pipeline_stage_regs. Expected values are pushed to a
// scoreboard queue when stimulus is driven and popped when outputs are checked.
// Flush checks are compiled in only when PIPE_FLUSH_EN is defined.

module tb_pipeline_stage_regs;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
`ifdef PIPE_FLUSH_EN
   logic        ifid_flush = 1'b0;
   logic        idex_flush = 1'b0;
   logic        exmem_flush = 1'b0;
`endif
   logic        ifid_en = 1'b0;
   logic [31:0] ifid_instr_i = '0, ifid_instr_o;
   logic [63:0] ifid_pc_i = '0, ifid_pc_o;
   logic        idex_en = 1'b0;
   logic [63:0] idex_rd1_i = '0, idex_rd1_o;
   logic [63:0] idex_rd2_i = '0, idex_rd2_o;
   logic [63:0] idex_pc_i = '0, idex_pc_o;
   logic [63:0] idex_se_i = '0, idex_se_o;
   logic [4:0]  idex_rn_i = '0, idex_rn_o;
   logic [4:0]  idex_rm_i = '0, idex_rm_o;
   logic [4:0]  idex_rd_i = '0, idex_rd_o;
   logic [5:0]  idex_ex_i = '0, idex_ex_o;
   logic [4:0]  idex_m_i = '0, idex_m_o;
   logic [1:0]  idex_wb_i = '0, idex_wb_o;
   logic        exmem_en = 1'b0;
   logic [63:0] exmem_alu_i = '0, exmem_alu_o;
   logic [63:0] exmem_wdata_i = '0, exmem_wdata_o;
   logic [63:0] exmem_addr_i = '0, exmem_addr_o;
   logic [4:0]  exmem_rd_i = '0, exmem_rd_o;
   logic [4:0]  exmem_m_i = '0, exmem_m_o;
   logic [1:0]  exmem_wb_i = '0, exmem_wb_o;
   logic [3:0]  exmem_aluflag_i = '0, exmem_aluflag_o;
   logic [3:0]  exmem_flag_i = '0, exmem_flag_o;

   int          nChecks = 0;
   int          nFail   = 0;
   logic [63:0] expQ[$];

   pipeline_stage_regs dut (
      .clk(clk), .rst(rst),
`ifdef PIPE_FLUSH_EN
      .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
`endif
      .ifid_en(ifid_en), .ifid_instr_i(ifid_instr_i), .ifid_instr_o(ifid_instr_o),
      .ifid_pc_i(ifid_pc_i), .ifid_pc_o(ifid_pc_o),
      .idex_en(idex_en), .idex_rd1_i(idex_rd1_i), .idex_rd1_o(idex_rd1_o),
      .idex_rd2_i(idex_rd2_i), .idex_rd2_o(idex_rd2_o),
      .idex_pc_i(idex_pc_i), .idex_pc_o(idex_pc_o),
      .idex_se_i(idex_se_i), .idex_se_o(idex_se_o),
      .idex_rn_i(idex_rn_i), .idex_rn_o(idex_rn_o),
      .idex_rm_i(idex_rm_i), .idex_rm_o(idex_rm_o),
      .idex_rd_i(idex_rd_i), .idex_rd_o(idex_rd_o),
      .idex_ex_i(idex_ex_i), .idex_ex_o(idex_ex_o),
      .idex_m_i(idex_m_i), .idex_m_o(idex_m_o),
      .idex_wb_i(idex_wb_i), .idex_wb_o(idex_wb_o),
      .exmem_en(exmem_en), .exmem_alu_i(exmem_alu_i), .exmem_alu_o(exmem_alu_o),
      .exmem_wdata_i(exmem_wdata_i), .exmem_wdata_o(exmem_wdata_o),
      .exmem_addr_i(exmem_addr_i), .exmem_addr_o(exmem_addr_o),
      .exmem_rd_i(exmem_rd_i), .exmem_rd_o(exmem_rd_o),
      .exmem_m_i(exmem_m_i), .exmem_m_o(exmem_m_o),
      .exmem_wb_i(exmem_wb_i), .exmem_wb_o(exmem_wb_o),
      .exmem_aluflag_i(exmem_aluflag_i), .exmem_aluflag_o(exmem_aluflag_o),
      .exmem_flag_i(exmem_flag_i), .exmem_flag_o(exmem_flag_o)
   );

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   // Queue one expected value for a later check
   task automatic pushExp(input logic [63:0] v);
      expQ.push_back(v);
   endtask

   // Pop the oldest expected value and compare it against an observed output
   task automatic checkOutput(input string tag, input logic [63:0] obs);
      logic [63:0] exp;
      nChecks++;
      if (expQ.size() == 0) begin
         nFail++;
         $display("[TB] FAIL %s: scoreboard empty, observed %h", tag, obs);
      end else begin
         exp = expQ.pop_front();
         assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
         end
      end
   endtask

   // Drive at the falling edge so inputs are settled well before capture
   task automatic applyStimulus();
      @(negedge clk);
   endtask

   // Advance past the capturing edge before sampling outputs
   task automatic waitCapture();
      @(posedge clk);
      #1;
   endtask

   // Directed test sequence
   initial begin
      logic [63:0] mAlu, mSe, v;
      logic        eA, eB;

      // Reset state
      #2;
      pushExp(64'h0); pushExp(64'h0); pushExp(64'h0); pushExp(64'h0);
      checkOutput("rst_instr", 64'(ifid_instr_o));
      checkOutput("rst_idex_wb", 64'(idex_wb_o));
      checkOutput("rst_exmem_m", 64'(exmem_m_o));
      checkOutput("rst_exmem_alu", exmem_alu_o);

      // Load all stages with nonzero data
      applyStimulus();
      rst = 1'b1;
      ifid_en = 1'b1; idex_en = 1'b1; exmem_en = 1'b1;
      ifid_instr_i = 32'h91000421; ifid_pc_i = 64'h10;
      idex_wb_i = 2'b11; idex_rd1_i = 64'h55;
      exmem_m_i = 5'b00010; exmem_alu_i = 64'h99;
      pushExp(64'h91000421); pushExp(64'h10); pushExp(64'h3); pushExp(64'h2); pushExp(64'h99);
      waitCapture();
      checkOutput("load_instr", 64'(ifid_instr_o));
      checkOutput("load_pc", ifid_pc_o);
      checkOutput("load_idex_wb", 64'(idex_wb_o));
      checkOutput("load_exmem_m", 64'(exmem_m_o));
      checkOutput("load_exmem_alu", exmem_alu_o);

      // Asynchronous reset between edges
      #2;
      rst = 1'b0;
      pushExp(64'h0); pushExp(64'h0); pushExp(64'h0); pushExp(64'h0); pushExp(64'h0);
      #1;
      checkOutput("async_instr", 64'(ifid_instr_o));
      checkOutput("async_pc", ifid_pc_o);
      checkOutput("async_idex_wb", 64'(idex_wb_o));
      checkOutput("async_idex_rd1", idex_rd1_o);
      checkOutput("async_exmem_alu", exmem_alu_o);

      // Release with all stages disabled: outputs remain zero
      applyStimulus();
      rst = 1'b1;
      ifid_en = 1'b0; idex_en = 1'b0; exmem_en = 1'b0;
      pushExp(64'h0); pushExp(64'h0);
      waitCapture();
      checkOutput("rel_hold_instr", 64'(ifid_instr_o));
      checkOutput("rel_hold_alu", exmem_alu_o);

      // Pass-through: IF/ID then ID/EX chained gives two-cycle delay
      ifid_en = 1'b1; idex_en = 1'b1; exmem_en = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         applyStimulus();
         idex_pc_i = ifid_pc_o;
         ifid_pc_i = 64'(4 * k);
         pushExp(64'(4 * k));
         if (k >= 2) pushExp(64'(4 * (k - 1)));
         waitCapture();
         checkOutput("pass_ifid_pc", ifid_pc_o);
         if (k >= 2) checkOutput("pass_idex_pc", idex_pc_o);
      end

      // Stall IF/ID for two cycles while the instruction input changes
      applyStimulus();
      ifid_instr_i = 32'h8B020020;
      pushExp(64'h8B020020);
      waitCapture();
      checkOutput("stall_load", 64'(ifid_instr_o));
      for (int k = 0; k < 2; k++) begin
         applyStimulus();
         ifid_en = 1'b0;
         ifid_instr_i = 32'hCAFE0000 + 32'(k);
         ifid_pc_i = 64'h100 + 64'(k);
         pushExp(64'h8B020020); pushExp(64'h10);
         waitCapture();
         checkOutput("stall_hold_instr", 64'(ifid_instr_o));
         checkOutput("stall_hold_pc", ifid_pc_o);
      end
      applyStimulus();
      ifid_en = 1'b1;
      ifid_instr_i = 32'hAA000001;
      pushExp(64'hAA000001);
      waitCapture();
      checkOutput("stall_release", 64'(ifid_instr_o));

      // Independence: ID/EX frozen while EX/MEM loads
      applyStimulus();
      idex_rd1_i = 64'h1111; idex_ex_i = 6'h2A; idex_rd_i = 5'h07;
      pushExp(64'h1111);
      waitCapture();
      checkOutput("indep_setup_rd1", idex_rd1_o);
      applyStimulus();
      idex_en = 1'b0;
      idex_rd1_i = 64'h2222; idex_ex_i = 6'h15; idex_rd_i = 5'h1C;
      exmem_alu_i = 64'hDEAD_BEEF;
      pushExp(64'hDEADBEEF); pushExp(64'h1111); pushExp(64'h2A); pushExp(64'h07);
      waitCapture();
      checkOutput("indep_exmem_alu", exmem_alu_o);
      checkOutput("indep_idex_rd1", idex_rd1_o);
      checkOutput("indep_idex_ex", 64'(idex_ex_o));
      checkOutput("indep_idex_rd", 64'(idex_rd_o));

      // Field integrity: packed controls and flags pass bit-exact
      applyStimulus();
      idex_en = 1'b1;
      idex_m_i = 5'b10101; idex_wb_i = 2'b10; idex_ex_i = 6'b100110;
      idex_rn_i = 5'h1F; idex_rm_i = 5'h0A; idex_rd_i = 5'h15;
      idex_se_i = 64'hFFFF_FFFF_FFFF_FFF0; idex_rd2_i = 64'h8000_0000_0000_0001;
      exmem_aluflag_i = 4'b1001; exmem_flag_i = 4'b0110;
      exmem_m_i = 5'b01011; exmem_wb_i = 2'b01; exmem_rd_i = 5'h1E;
      exmem_wdata_i = 64'h0123_4567_89AB_CDEF; exmem_addr_i = 64'hFEDC_BA98_7654_3210;
      pushExp(64'h15); pushExp(64'h2); pushExp(64'h26); pushExp(64'h1F); pushExp(64'h0A);
      pushExp(64'h15); pushExp(64'hFFFF_FFFF_FFFF_FFF0); pushExp(64'h8000_0000_0000_0001);
      pushExp(64'h9); pushExp(64'h6); pushExp(64'h0B); pushExp(64'h1); pushExp(64'h1E);
      pushExp(64'h0123_4567_89AB_CDEF); pushExp(64'hFEDC_BA98_7654_3210);
      waitCapture();
      checkOutput("fld_idex_m", 64'(idex_m_o));
      checkOutput("fld_idex_wb", 64'(idex_wb_o));
      checkOutput("fld_idex_ex", 64'(idex_ex_o));
      checkOutput("fld_idex_rn", 64'(idex_rn_o));
      checkOutput("fld_idex_rm", 64'(idex_rm_o));
      checkOutput("fld_idex_rd", 64'(idex_rd_o));
      checkOutput("fld_idex_se", idex_se_o);
      checkOutput("fld_idex_rd2", idex_rd2_o);
      checkOutput("fld_aluflag", 64'(exmem_aluflag_o));
      checkOutput("fld_flag", 64'(exmem_flag_o));
      checkOutput("fld_exmem_m", 64'(exmem_m_o));
      checkOutput("fld_exmem_wb", 64'(exmem_wb_o));
      checkOutput("fld_exmem_rd", 64'(exmem_rd_o));
      checkOutput("fld_wdata", exmem_wdata_o);
      checkOutput("fld_addr", exmem_addr_o);

      // Random enables: each stage loads or holds as a whole
      mAlu = 64'hDEAD_BEEF;
      mSe  = 64'hFFFF_FFFF_FFFF_FFF0;
      for (int k = 0; k < 10; k++) begin
         applyStimulus();
         eA = 1'($urandom_range(0, 1));
         eB = 1'($urandom_range(0, 1));
         exmem_en = eA; idex_en = eB;
         v = {$urandom(), $urandom()};
         exmem_alu_i = v;
         if (eA) mAlu = v;
         v = {$urandom(), $urandom()};
         idex_se_i = v;
         if (eB) mSe = v;
         pushExp(mAlu); pushExp(mSe);
         waitCapture();
         checkOutput("rnd_exmem_alu", exmem_alu_o);
         checkOutput("rnd_idex_se", idex_se_o);
      end

`ifdef PIPE_FLUSH_EN
      // Setup known contents before flushing
      applyStimulus();
      ifid_en = 1'b1; idex_en = 1'b1; exmem_en = 1'b1;
      ifid_instr_i = 32'h1234_5678; ifid_pc_i = 64'h40;
      exmem_m_i = 5'h1F; exmem_wb_i = 2'b11; exmem_alu_i = 64'h77;
      pushExp(64'h12345678); pushExp(64'h1F);
      waitCapture();
      checkOutput("fl_setup_instr", 64'(ifid_instr_o));
      checkOutput("fl_setup_exmem_m", 64'(exmem_m_o));

      // Flush all stages: bubbles inserted, data loads or holds per enable
      applyStimulus();
      ifid_flush = 1'b1; idex_flush = 1'b1; exmem_flush = 1'b1;
      ifid_en = 1'b0; exmem_en = 1'b0; idex_en = 1'b1;
      ifid_instr_i = 32'hFFFF_FFFF; ifid_pc_i = 64'h80;
      idex_ex_i = 6'h3F; idex_m_i = 5'h1F; idex_wb_i = 2'b11; idex_rd1_i = 64'h5;
      exmem_alu_i = 64'h88;
      pushExp(64'h0); pushExp(64'h40); pushExp(64'h0); pushExp(64'h0); pushExp(64'h0);
      pushExp(64'h5); pushExp(64'h0); pushExp(64'h0); pushExp(64'h77);
      waitCapture();
      checkOutput("fl_ifid_instr", 64'(ifid_instr_o));
      checkOutput("fl_ifid_pc", ifid_pc_o);
      checkOutput("fl_idex_ex", 64'(idex_ex_o));
      checkOutput("fl_idex_m", 64'(idex_m_o));
      checkOutput("fl_idex_wb", 64'(idex_wb_o));
      checkOutput("fl_idex_rd1", idex_rd1_o);
      checkOutput("fl_exmem_m", 64'(exmem_m_o));
      checkOutput("fl_exmem_wb", 64'(exmem_wb_o));
      checkOutput("fl_exmem_alu", exmem_alu_o);

      // Flush released: controls load again
      applyStimulus();
      ifid_flush = 1'b0; idex_flush = 1'b0; exmem_flush = 1'b0;
      pushExp(64'h3F); pushExp(64'h3);
      waitCapture();
      checkOutput("fl_rel_idex_ex", 64'(idex_ex_o));
      checkOutput("fl_rel_idex_wb", 64'(idex_wb_o));
`endif

      if (expQ.size() != 0) begin
         nChecks++;
         nFail++;
         $display("[TB] FAIL scoreboard_drain: %0d left, required 0", expQ.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
